// File: rtl/icache_param_pkg.sv
// Shared types for the instruction cache: word type, controller states and
// the line-address layout for the default geometry.
package icache_param_pkg;

   typedef logic [31:0] word_t;

   localparam int ICACHE_NSETS    = 16;
   localparam int ICACHE_BLKWORDS = 2;
   localparam int ICACHE_WOFF     = (ICACHE_BLKWORDS > 1) ? $clog2(ICACHE_BLKWORDS) : 1;
   localparam int ICACHE_IDX      = $clog2(ICACHE_NSETS);
   localparam int ICACHE_TAGW     = 30 - ICACHE_WOFF - ICACHE_IDX;

   typedef enum logic {
      IC_IDLE = 1'b0,
      IC_FILL = 1'b1
   } icache_state_t;

   typedef struct packed {
      logic [ICACHE_TAGW-1:0] tag;
      logic [ICACHE_IDX-1:0]  idx;
      logic [ICACHE_WOFF-1:0] woff;
      logic [1:0]             boff;
   } icache_laddr_t;

endpackage

// File: rtl/icache_param.sv
// Direct-mapped instruction cache: same-cycle hits, multi-word block fill on
// miss, whole-cache invalidate and saturating hit/miss counters.
module icache_param
   import icache_param_pkg::*;
#(
   parameter int NSETS    = ICACHE_NSETS,
   parameter int BLKWORDS = ICACHE_BLKWORDS,
   parameter int CNTW     = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            imemREN,
   input  logic [31:0]     imemaddr,
   output logic            ihit,
   output logic [31:0]     imemload,
   input  logic            inval,
   output logic            iREN,
   output logic [31:0]     iaddr,
   input  logic            iwait,
   input  logic [31:0]     iload,
   output logic [CNTW-1:0] hit_count,
   output logic [CNTW-1:0] miss_count
);

   localparam int WOFF = $clog2(BLKWORDS);
   localparam int IDXW = $clog2(NSETS);
   localparam int TAGW = 30 - WOFF - IDXW;
   // keep the word counter at least one bit wide for single-word lines
   localparam int WCW  = (WOFF > 0) ? WOFF : 1;

   icache_state_t                          r_state;
   logic [NSETS-1:0]                       r_valid;
   logic [NSETS-1:0][TAGW-1:0]             r_tags;
   logic [NSETS-1:0][BLKWORDS-1:0][31:0]   r_data;
   logic [TAGW-1:0]                        r_ftag;
   logic [IDXW-1:0]                        r_fidx;
   logic [WCW-1:0]                         r_wcnt;
   logic [CNTW-1:0]                        r_hit_cnt;
   logic [CNTW-1:0]                        r_miss_cnt;

   word_t           w_wa;
   logic [TAGW-1:0] w_tag;
   logic [IDXW-1:0] w_idx;
   logic [WCW-1:0]  w_woff;
   logic            w_hit;
   logic            w_last;
   word_t           w_faddr;
   logic            w_unused;

   assign w_unused = ^imemaddr[1:0];
   assign w_wa     = {2'b00, imemaddr[31:2]};
   assign w_woff   = WCW'(w_wa & 32'(BLKWORDS-1));
   assign w_idx    = IDXW'(w_wa >> WOFF);
   assign w_tag    = TAGW'(w_wa >> (WOFF + IDXW));

   assign w_hit    = (r_state == IC_IDLE) & imemREN & r_valid[w_idx] & (r_tags[w_idx] == w_tag);
   assign w_last   = (r_wcnt == WCW'(BLKWORDS-1));
   assign w_faddr  = (32'(r_ftag) << (IDXW + WOFF + 2)) | (32'(r_fidx) << (WOFF + 2)) | (32'(r_wcnt) << 2);

   assign ihit       = w_hit & ~inval;
   assign imemload   = r_data[w_idx][w_woff];
   assign iREN       = (r_state == IC_FILL);
   assign iaddr      = (r_state == IC_FILL) ? w_faddr : '0;
   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= IC_IDLE;
         r_valid    <= '0;
         r_tags     <= '0;
         r_ftag     <= '0;
         r_fidx     <= '0;
         r_wcnt     <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (inval) begin
         // abort any fill; the partially written line stays invalid
         r_valid <= '0;
         r_state <= IC_IDLE;
         r_wcnt  <= '0;
      end else begin
         case (r_state)
            IC_IDLE: begin
               if (w_hit) begin
                  if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNTW'(1);
               end else if (imemREN) begin
                  r_ftag  <= w_tag;
                  r_fidx  <= w_idx;
                  r_wcnt  <= '0;
                  r_state <= IC_FILL;
                  if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNTW'(1);
               end
            end
            IC_FILL: begin
               if (!iwait) begin
                  if (w_last) begin
                     r_tags[r_fidx]  <= r_ftag;
                     r_valid[r_fidx] <= 1'b1;
                     r_wcnt          <= '0;
                     r_state         <= IC_IDLE;
                  end else begin
                     r_wcnt <= r_wcnt + WCW'(1);
                  end
               end
            end
            default: r_state <= IC_IDLE;
         endcase
      end
   end

   // data array has no reset: contents are only read behind a valid bit
   always_ff @(posedge CLK) begin
      if (r_state == IC_FILL && !iwait && !inval)
         r_data[r_fidx][r_wcnt] <= iload;
   end

endmodule

// File: tb/tb_icache_param.sv
// Directed bench for icache_param: cold miss, conflict, stalls, mid-fill
// address change, invalidate, async reset and counter saturation.
module tb_icache_param;

   logic        CLK, RST;
   logic        imemREN, inval, iwait;
   logic [31:0] imemaddr, iload;
   logic        ihit, iREN;
   logic [31:0] imemload, iaddr;
   logic [31:0] hit_count, miss_count;

   logic        s_ihit, s_iREN;
   logic [31:0] s_imemload, s_iaddr;
   logic [3:0]  s_hit_count, s_miss_count;

   int total = 0;
   int bad   = 0;

   icache_param #(.NSETS(16), .BLKWORDS(2), .CNTW(32)) u_dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .inval(inval), .iREN(iREN),
      .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   icache_param #(.NSETS(16), .BLKWORDS(2), .CNTW(4)) u_sat (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(s_ihit), .imemload(s_imemload), .inval(inval), .iREN(s_iREN),
      .iaddr(s_iaddr), .iwait(iwait), .iload(iload),
      .hit_count(s_hit_count), .miss_count(s_miss_count)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   assign iload = mem(iaddr);

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; imemREN = 1'b0; inval = 1'b0; iwait = 1'b0; imemaddr = '0;
      tick(); tick();
      chk("rst_ihit", 32'(ihit), 0);
      chk("rst_iren", 32'(iREN), 0);
      chk("rst_iaddr", iaddr, 0);
      chk("rst_hits", hit_count, 0);
      chk("rst_miss", miss_count, 0);
      RST = 1'b0;
      tick();

      // cold miss on 0x40
      imemREN = 1'b1; imemaddr = 32'h40; #1;
      chk("cold_nohit", 32'(ihit), 0);
      tick();
      chk("cold_miss", miss_count, 1);
      chk("cold_iren", 32'(iREN), 1);
      chk("cold_a0", iaddr, 32'h40);
      tick();
      chk("cold_a1", iaddr, 32'h44);
      tick();
      chk("cold_hit", 32'(ihit), 1);
      chk("cold_data", imemload, mem(32'h40));
      chk("cold_iren0", 32'(iREN), 0);
      tick();
      imemaddr = 32'h44; #1;
      chk("w1_hit", 32'(ihit), 1);
      chk("w1_data", imemload, mem(32'h44));
      tick();
      chk("hits2", hit_count, 2);

      // conflict: 0xC0 shares index 8 with 0x40
      imemaddr = 32'hC0; #1;
      chk("conf_nohit", 32'(ihit), 0);
      tick(); tick(); tick();
      chk("conf_hit", 32'(ihit), 1);
      chk("conf_data", imemload, mem(32'hC0));
      chk("conf_miss", miss_count, 2);
      imemaddr = 32'h40; #1;
      chk("conf_evict", 32'(ihit), 0);
      tick();
      chk("conf_miss3", miss_count, 3);
      tick(); tick();
      imemREN = 1'b0;

      // iwait stall: 3 wait cycles per word on 0x200
      imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b1;
      tick();
      for (int w = 0; w < 2; w++) begin
         for (int s = 0; s < 3; s++) begin
            chk("stall_nohit", 32'(ihit), 0);
            chk("stall_addr", iaddr, 32'h200 + 32'(w * 4));
            tick();
         end
         iwait = 1'b0;
         tick();
         iwait = 1'b1;
      end
      iwait = 1'b0; #1;
      chk("stall_hit", 32'(ihit), 1);
      chk("stall_data", imemload, mem(32'h200));
      chk("stall_miss", miss_count, 4);
      imemREN = 1'b0;

      // inval with line 8 resident: hit suppressed, counters frozen
      imemREN = 1'b1; imemaddr = 32'h40; inval = 1'b1; #1;
      chk("inv_nohit", 32'(ihit), 0);
      tick();
      inval = 1'b0; #1;
      chk("inv_hits", hit_count, 2);
      chk("inv_miss", miss_count, 4);
      chk("inv_gone", 32'(ihit), 0);

      // mid-fill address change: 0x40 fill completes, 0x100 then misses
      tick();
      imemaddr = 32'h100;
      tick(); tick();
      chk("chg_nohit", 32'(ihit), 0);
      chk("chg_idle", 32'(iREN), 0);
      imemaddr = 32'h40; #1;
      chk("chg_line8", 32'(ihit), 1);
      tick();
      chk("chg_hits", hit_count, 3);
      imemaddr = 32'h100;
      tick();
      chk("chg_miss", miss_count, 6);

      // inval mid-fill of 0x100
      inval = 1'b1; #1;
      chk("invf_nohit", 32'(ihit), 0);
      tick();
      chk("invf_idle", 32'(iREN), 0);
      chk("invf_miss", miss_count, 6);
      inval = 1'b0; #1;
      chk("invf_0x100", 32'(ihit), 0);
      imemaddr = 32'h40; #1;
      chk("invf_0x40", 32'(ihit), 0);
      imemREN = 1'b0;
      tick();

      // async reset in the middle of a fill
      imemREN = 1'b1; imemaddr = 32'h40;
      tick();
      chk("ar_fill", 32'(iREN), 1);
      #2 RST = 1'b1;
      #1;
      chk("ar_iren", 32'(iREN), 0);
      chk("ar_iaddr", iaddr, 0);
      chk("ar_ihit", 32'(ihit), 0);
      chk("ar_miss", miss_count, 0);
      chk("ar_hits", hit_count, 0);
      tick();
      RST = 1'b0;

      // saturation: 20 hits on 0x40 into a 4-bit counter
      tick(); tick(); tick();
      chk("sat_ready", 32'(ihit), 1);
      for (int k = 0; k < 20; k++) tick();
      chk("sat_hits32", hit_count, 20);
      chk("sat_hits4", 32'(s_hit_count), 15);
      chk("sat_miss4", 32'(s_miss_count), 1);
      imemREN = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
